// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

  // Branch targets are always word aligned; low address bits from the resolver are dropped.
  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: icache handshake, hazard/redirect controls and IF/ID outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t instr_o;
  word_t npc_o;
  word_t curr_pc_o;
  logic  fetch_valid;
  logic  flush_o;

  modport fetch (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output iREN, iaddr, instr_o, npc_o, curr_pc_o, fetch_valid, flush_o
  );

  modport icache (
    output ihit, iload,
    input  iREN, iaddr
  );

  modport hazard (
    output stall, redirect, redirect_pc, halt,
    input  instr_o, npc_o, curr_pc_o, fetch_valid, flush_o
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the icache, and absorbs redirects,
// including one that lands while a miss is still outstanding.
//
//   state  | meaning
//   RUN    | normal fetch, instruction delivered on ihit
//   DRAIN  | redirect seen mid-miss; finish old read, discard it, then jump
//   HALTED | fetch stopped until reset
module fetch_unit #(
  parameter fetch_unit_pkg::word_t PC_INIT = 32'h0000_0000,
  parameter int unsigned           PC_STEP = fetch_unit_pkg::PC_STEP
) (
  input  logic                CLK,
  input  logic                nRST,
  fetch_unit_if.fetch         fif
);
  import fetch_unit_pkg::*;

  fetch_state_t r_state, w_state_n;
  word_t        r_pc, r_pending;
  word_t        w_pc_n, w_pending_n;
  word_t        w_redir_tgt;
  word_t        w_step;

  assign w_step      = word_t'(PC_STEP);
  assign w_redir_tgt = align_word(fif.redirect_pc);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= RUN;
      r_pc      <= PC_INIT;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_pending <= w_pending_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_pending_n = r_pending;
    case (r_state)
      RUN: begin
        if (fif.halt) begin
          w_state_n = HALTED;
        end else if (fif.redirect) begin
          if (fif.ihit) begin
            w_pc_n = w_redir_tgt;
          end else begin
            // Keep iaddr on the missing line; jump once the cache answers.
            w_pending_n = w_redir_tgt;
            w_state_n   = DRAIN;
          end
        end else if (fif.ihit && !fif.stall) begin
          w_pc_n = r_pc + w_step;
        end
      end
      DRAIN: begin
        if (fif.halt) begin
          w_state_n = HALTED;
        end else begin
          if (fif.redirect) begin
            w_pending_n = w_redir_tgt;
          end
          if (fif.ihit) begin
            w_pc_n    = fif.redirect ? w_redir_tgt : r_pending;
            w_state_n = RUN;
          end
        end
      end
      HALTED: begin
        w_state_n = HALTED;
      end
      default: begin
        w_state_n = RUN;
      end
    endcase
  end

  assign fif.iaddr     = r_pc;
  assign fif.curr_pc_o = r_pc;
  assign fif.npc_o     = r_pc + w_step;
  assign fif.instr_o   = fif.iload;
  assign fif.iREN      = (r_state != HALTED);

  // Gated by nRST so nothing reaches IF/ID while reset is held.
  assign fif.flush_o     = nRST & fif.redirect & (r_state != HALTED);
  assign fif.fetch_valid = nRST & (r_state == RUN) & fif.ihit & ~fif.stall
                         & ~fif.redirect & ~fif.halt;

endmodule
